// File: rtl/command_parser.sv
// GX command-stream parser: fetches opcodes/operands over the CPRead/CPValid
// byte-window handshake and emits register-write strobes and draw descriptors.
module command_parser #(
  parameter int unsigned RETRY_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        CPRead,
  output logic [2:0]  CPBytes,
  input  logic        CPValid,
  input  logic [31:0] CPData,
  output logic        CPRegWrite,
  output logic [7:0]  CPRegAddr,
  output logic [31:0] CPRegData,
  output logic        XFRegWrite,
  output logic [15:0] XFRegAddr,
  output logic [31:0] XFRegData,
  output logic        BPRegWrite,
  output logic [31:0] BPRegData,
  output logic        DrawStart,
  output logic [2:0]  DrawPrimitive,
  output logic [2:0]  DrawVAT,
  output logic [15:0] DrawCount,
  input  logic        DrawDone,
  output logic        BadOpcode,
  output logic        Busy
);

  localparam logic [2:0] S_OP        = 3'd0;
  localparam logic [2:0] S_CP_ADDR   = 3'd1;
  localparam logic [2:0] S_CP_DATA   = 3'd2;
  localparam logic [2:0] S_XF_HDR    = 3'd3;
  localparam logic [2:0] S_XF_DATA   = 3'd4;
  localparam logic [2:0] S_BP_DATA   = 3'd5;
  localparam logic [2:0] S_DRAW_CNT  = 3'd6;
  localparam logic [2:0] S_DRAW_WAIT = 3'd7;

  // ARM only follows reset so CPRead stays low while resetn is asserted.
  localparam logic [1:0] PH_ARM   = 2'd0;
  localparam logic [1:0] PH_ISSUE = 2'd1;
  localparam logic [1:0] PH_WAIT  = 2'd2;

  logic [2:0]  state_q, state_d, ns;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  wait_q, wait_d;
  logic        fetch;
  logic        cpread_q, cpread_d;
  logic [2:0]  cpbytes_q, cpbytes_d;
  logic [5:0]  op_q, op_d;
  logic [7:0]  cp_addr_q, cp_addr_d;
  logic [15:0] xf_addr_q, xf_addr_d;
  logic [16:0] xf_rem_q, xf_rem_d;
  logic        cpw_q, cpw_d, xfw_q, xfw_d, bpw_q, bpw_d, bad_q, bad_d;
  logic        ds_q, ds_d, busy_q, busy_d;
  logic [7:0]  cpa_q, cpa_d;
  logic [31:0] cpd_q, cpd_d, xfd_q, xfd_d, bpd_q, bpd_d;
  logic [15:0] xfa_q, xfa_d, dc_q, dc_d;
  logic [2:0]  dp_q, dp_d, dv_q, dv_d;
  logic [31:0] field4;
  logic [15:0] field2;

  assign field4 = {CPData[7:0], CPData[15:8], CPData[23:16], CPData[31:24]};
  assign field2 = {CPData[7:0], CPData[15:8]};

  function automatic logic [2:0] field_bytes(input logic [2:0] s);
    case (s)
      S_OP, S_CP_ADDR: field_bytes = 3'd1;
      S_DRAW_CNT:      field_bytes = 3'd2;
      default:         field_bytes = 3'd4;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    cpread_d  = 1'b0;
    cpbytes_d = cpbytes_q;
    op_d      = op_q;
    cp_addr_d = cp_addr_q;
    xf_addr_d = xf_addr_q;
    xf_rem_d  = xf_rem_q;
    cpw_d     = 1'b0;
    xfw_d     = 1'b0;
    bpw_d     = 1'b0;
    bad_d     = 1'b0;
    cpa_d     = cpa_q;
    cpd_d     = cpd_q;
    xfa_d     = xfa_q;
    xfd_d     = xfd_q;
    bpd_d     = bpd_q;
    ds_d      = ds_q;
    dp_d      = dp_q;
    dv_d      = dv_q;
    dc_d      = dc_q;
    fetch     = 1'b0;
    ns        = state_q;
    if (state_q == S_DRAW_WAIT) begin
      if (DrawDone) begin
        ds_d  = 1'b0;
        fetch = 1'b1;
        ns    = S_OP;
      end
    end else begin
      case (phase_q)
        PH_ARM:   fetch = 1'b1;
        PH_ISSUE: begin
          phase_d = PH_WAIT;
          wait_d  = '0;
        end
        default: begin
          if (CPValid) begin
            fetch = 1'b1;
            case (state_q)
              S_OP: begin
                op_d = CPData[5:0];
                if (CPData[7:0] == 8'h00)        ns = S_OP;
                else if (CPData[7:0] == 8'h08)   ns = S_CP_ADDR;
                else if (CPData[7:0] == 8'h10)   ns = S_XF_HDR;
                else if (CPData[7:0] == 8'h61)   ns = S_BP_DATA;
                else if (CPData[7:6] == 2'b10)   ns = S_DRAW_CNT;
                else begin
                  bad_d = 1'b1;
                  ns    = S_OP;
                end
              end
              S_CP_ADDR: begin
                cp_addr_d = CPData[7:0];
                ns        = S_CP_DATA;
              end
              S_CP_DATA: begin
                cpw_d = 1'b1;
                cpa_d = cp_addr_q;
                cpd_d = field4;
                ns    = S_OP;
              end
              S_XF_HDR: begin
                xf_rem_d  = {1'b0, field4[31:16]} + 17'd1;
                xf_addr_d = field4[15:0];
                ns        = S_XF_DATA;
              end
              S_XF_DATA: begin
                xfw_d     = 1'b1;
                xfa_d     = xf_addr_q;
                xfd_d     = field4;
                xf_addr_d = xf_addr_q + 16'd1;
                xf_rem_d  = xf_rem_q - 17'd1;
                ns        = (xf_rem_q == 17'd1) ? S_OP : S_XF_DATA;
              end
              S_BP_DATA: begin
                bpw_d = 1'b1;
                bpd_d = field4;
                ns    = S_OP;
              end
              default: begin
                if (field2 == 16'd0) begin
                  ns = S_OP;
                end else begin
                  fetch   = 1'b0;
                  state_d = S_DRAW_WAIT;
                  ds_d    = 1'b1;
                  dp_d    = op_q[5:3];
                  dv_d    = op_q[2:0];
                  dc_d    = field2;
                end
              end
            endcase
          end else if (wait_q == 8'(RETRY_CYCLES - 1)) begin
            fetch = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      endcase
    end
    // Issue the next request on the same edge as the capture: one field per 2 cycles.
    if (fetch) begin
      state_d   = ns;
      phase_d   = PH_ISSUE;
      cpread_d  = 1'b1;
      cpbytes_d = field_bytes(ns);
    end
    busy_d = (state_d != S_OP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_OP;       phase_q <= PH_ARM;     wait_q <= '0;
      cpread_q <= 1'b0;      cpbytes_q <= '0;       op_q <= '0;
      cp_addr_q <= '0;       xf_addr_q <= '0;       xf_rem_q <= '0;
      cpw_q <= 1'b0;         xfw_q <= 1'b0;         bpw_q <= 1'b0;
      bad_q <= 1'b0;         ds_q <= 1'b0;          busy_q <= 1'b0;
      cpa_q <= '0;           cpd_q <= '0;           xfa_q <= '0;
      xfd_q <= '0;           bpd_q <= '0;           dp_q <= '0;
      dv_q <= '0;            dc_q <= '0;
    end else begin
      state_q <= state_d;    phase_q <= phase_d;    wait_q <= wait_d;
      cpread_q <= cpread_d;  cpbytes_q <= cpbytes_d; op_q <= op_d;
      cp_addr_q <= cp_addr_d; xf_addr_q <= xf_addr_d; xf_rem_q <= xf_rem_d;
      cpw_q <= cpw_d;        xfw_q <= xfw_d;        bpw_q <= bpw_d;
      bad_q <= bad_d;        ds_q <= ds_d;          busy_q <= busy_d;
      cpa_q <= cpa_d;        cpd_q <= cpd_d;        xfa_q <= xfa_d;
      xfd_q <= xfd_d;        bpd_q <= bpd_d;        dp_q <= dp_d;
      dv_q <= dv_d;          dc_q <= dc_d;
    end
  end

  assign CPRead        = cpread_q;
  assign CPBytes       = cpbytes_q;
  assign CPRegWrite    = cpw_q;
  assign CPRegAddr     = cpa_q;
  assign CPRegData     = cpd_q;
  assign XFRegWrite    = xfw_q;
  assign XFRegAddr     = xfa_q;
  assign XFRegData     = xfd_q;
  assign BPRegWrite    = bpw_q;
  assign BPRegData     = bpd_q;
  assign DrawStart     = ds_q;
  assign DrawPrimitive = dp_q;
  assign DrawVAT       = dv_q;
  assign DrawCount     = dc_q;
  assign BadOpcode     = bad_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_command_parser.sv
// Randomized bench for command_parser: a byte-stream/command-level model
// produces the expected strobe sequence; a deserializer model feeds the DUT.
module tb_command_parser;
  localparam int RETRY = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        CPRead, CPValid;
  logic [2:0]  CPBytes;
  logic [31:0] CPData;
  logic        CPRegWrite, XFRegWrite, BPRegWrite;
  logic [7:0]  CPRegAddr;
  logic [31:0] CPRegData, XFRegData, BPRegData;
  logic [15:0] XFRegAddr, DrawCount;
  logic        DrawStart, DrawDone, BadOpcode, Busy;
  logic [2:0]  DrawPrimitive, DrawVAT;

  command_parser #(.RETRY_CYCLES(RETRY)) dut (
    .clk(clk), .resetn(resetn),
    .CPRead(CPRead), .CPBytes(CPBytes), .CPValid(CPValid), .CPData(CPData),
    .CPRegWrite(CPRegWrite), .CPRegAddr(CPRegAddr), .CPRegData(CPRegData),
    .XFRegWrite(XFRegWrite), .XFRegAddr(XFRegAddr), .XFRegData(XFRegData),
    .BPRegWrite(BPRegWrite), .BPRegData(BPRegData),
    .DrawStart(DrawStart), .DrawPrimitive(DrawPrimitive), .DrawVAT(DrawVAT),
    .DrawCount(DrawCount), .DrawDone(DrawDone), .BadOpcode(BadOpcode), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [63:0] exp_q[$];

  int cyc = 0, last_rd = 0, resp_cnt = 0, req_bytes = 0, stall = 0;
  int draw_age = 0, draw_target = 0, draw_hold = 0, xf_cnt = 0, nstb = 0;
  bit pending = 0, rd_prev = 0, ds_prev = 0;
  logic [31:0] dword;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ev(input int k, input logic [23:0] a, input logic [31:0] d);
    return {8'(k), a, d};
  endfunction

  task automatic obs_event(input string tag, input logic [63:0] obs);
    if (exp_q.size() == 0) check({tag, "_unexpected"}, obs, 64'hFFFF_FFFF_FFFF_FFFF);
    else check(tag, obs, exp_q.pop_front());
  endtask

  task automatic put32(input logic [31:0] w);
    stream.push_back(w[31:24]); stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);  stream.push_back(w[7:0]);
  endtask

  task automatic cmd_nop();
    stream.push_back(8'h00);
  endtask

  task automatic cmd_cp(input logic [7:0] a, input logic [31:0] d);
    stream.push_back(8'h08); stream.push_back(a); put32(d);
    exp_q.push_back(ev(1, 24'(a), d));
  endtask

  // base==0 gives random words, otherwise base, base+1, ...
  task automatic cmd_xf(input logic [15:0] addr, input int n, input logic [31:0] base);
    logic [31:0] w;
    stream.push_back(8'h10);
    put32({16'(n - 1), addr});
    for (int i = 0; i < n; i++) begin
      w = (base == 0) ? $urandom : base + 32'(i);
      put32(w);
      exp_q.push_back(ev(2, 24'((int'(addr) + i) % 65536), w));
    end
  endtask

  task automatic cmd_bp(input logic [31:0] d);
    stream.push_back(8'h61); put32(d);
    exp_q.push_back(ev(3, 24'd0, d));
  endtask

  task automatic cmd_draw(input logic [5:0] op, input logic [15:0] cnt);
    stream.push_back({2'b10, op}); stream.push_back(cnt[15:8]); stream.push_back(cnt[7:0]);
    if (cnt != 0) exp_q.push_back(ev(4, 24'(op), 32'(cnt)));
  endtask

  task automatic cmd_bad(input logic [7:0] b);
    stream.push_back(b);
    exp_q.push_back(ev(5, 24'd0, 32'd0));
  endtask

  task automatic drain();
    int n = 0;
    while ((stream.size() != 0 || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk); n++;
    end
    check("drain_done", 64'(n < 20000), 64'd1);
    repeat (30) @(negedge clk);
    check("idle_busy", 64'(Busy), 64'd0);
    check("exp_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      CPValid = 1'b0; DrawDone = 1'b0; pending = 0; resp_cnt = 0;
      rd_prev = 0; ds_prev = 0; draw_age = 0;
    end else begin
      cyc++;
      nstb = int'(CPRegWrite) + int'(XFRegWrite) + int'(BPRegWrite) + int'(BadOpcode)
           + int'(DrawStart && !ds_prev);
      if (nstb > 1) check("strobe_overlap", 64'(nstb), 64'd1);
      if (CPRegWrite) obs_event("cp_write", ev(1, 24'(CPRegAddr), CPRegData));
      if (XFRegWrite) begin
        xf_cnt++;
        obs_event("xf_write", ev(2, 24'(XFRegAddr), XFRegData));
      end
      if (BPRegWrite) obs_event("bp_write", ev(3, 24'd0, BPRegData));
      if (BadOpcode) obs_event("bad_opcode", ev(5, 24'd0, 32'd0));
      if (DrawStart) begin
        check("draw_no_cpread", 64'(CPRead), 64'd0);
        draw_age++;
        if (!ds_prev) begin
          obs_event("draw_desc", ev(4, 24'({DrawPrimitive, DrawVAT}), 32'(DrawCount)));
          check("draw_busy", 64'(Busy), 64'd1);
          draw_target = (draw_hold != 0) ? draw_hold : int'($urandom_range(1, 12));
        end
        DrawDone = (draw_age == draw_target);
      end else begin
        if (ds_prev) check("draw_len", 64'(draw_age), 64'(draw_target));
        draw_age = 0;
        DrawDone = ($urandom_range(0, 15) == 0);
      end
      ds_prev = DrawStart;

      CPValid = 1'b0;
      CPData  = $urandom;
      if (stall > 0) stall--;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          dword = $urandom;
          for (int i = 0; i < req_bytes; i++) dword[8*i +: 8] = stream.pop_front();
          CPData  = dword;
          CPValid = 1'b1;
          pending = 0;
        end
      end
      if (CPRead) begin
        check("cpread_pulse", 64'(rd_prev), 64'd0);
        if (pending) check("retry_gap", 64'(cyc - last_rd), 64'(RETRY + 1));
        pending   = 1;
        last_rd   = cyc;
        req_bytes = int'(CPBytes);
        if (stall == 0 && stream.size() >= req_bytes && $urandom_range(0, 7) != 0)
          resp_cnt = int'($urandom_range(1, RETRY));
        else
          resp_cnt = 0;
      end
      rd_prev = CPRead;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    resetn = 1'b0; CPValid = 1'b0; DrawDone = 1'b0; CPData = '0;
    #23;
    check("reset_outputs", 64'(|{CPRead, CPBytes, CPRegWrite, CPRegAddr, CPRegData, XFRegWrite,
          XFRegAddr, XFRegData, BPRegWrite, BPRegData, DrawStart, DrawPrimitive, DrawVAT,
          DrawCount, BadOpcode, Busy}), 64'd0);
    resetn = 1'b1;

    cmd_nop();
    cmd_cp(8'h30, 32'h1234_5678);
    cmd_xf(16'h1000, 3, 32'hA);
    cmd_xf(16'hFFFF, 2, 32'd0);
    draw_hold = 10;
    cmd_draw(6'h18, 16'h0004);
    drain();
    draw_hold = 0;
    cmd_draw(6'h18, 16'h0000);
    cmd_bad(8'h55);
    drain();

    stall = 5;
    cmd_bp(32'hDEAD_BEEF);
    drain();

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: cmd_nop();
        1: cmd_cp(8'($urandom), $urandom);
        2: cmd_xf(($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom),
                  int'($urandom_range(1, 4)), 32'd0);
        3: cmd_bp($urandom);
        4: cmd_draw(6'($urandom), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
        default: begin
          b = 8'($urandom);
          while (b == 8'h00 || b == 8'h08 || b == 8'h10 || b == 8'h61 || b[7:6] == 2'b10)
            b = 8'($urandom);
          cmd_bad(b);
        end
      endcase
      if ($urandom_range(0, 9) == 0) stall = int'($urandom_range(3, 8));
    end
    drain();

    xf_cnt = 0;
    cmd_xf(16'h2000, 8, 32'd0);
    n = 0;
    while (xf_cnt == 0 && n < 2000) begin
      @(negedge clk); n++;
    end
    check("xf_before_reset", 64'(xf_cnt > 0), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("midcmd_reset_outputs", 64'(|{CPRead, CPBytes, CPRegWrite, CPRegAddr, CPRegData,
          XFRegWrite, XFRegAddr, XFRegData, BPRegWrite, BPRegData, DrawStart, DrawPrimitive,
          DrawVAT, DrawCount, BadOpcode, Busy}), 64'd0);
    stream.delete();
    exp_q.delete();
    xf_cnt = 0;
    #20 resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("no_xf_after_reset", 64'(xf_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
